// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Counter encodings, counter reset value, address-bus width and default table geometry.
package branch_predictor_pkg;

  localparam int ADDR_W         = 32;
  localparam int BP_INDEX_BITS  = 7;
  localparam int BP_TAG_BITS    = 10;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / EX training bundle between the pipeline and the branch predictor.
// master = pipeline side (PC register + EX), slave = predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic              rdy;
  logic [ADDR_W-1:0] if_pc;
  logic              pre_jmp;
  logic [ADDR_W-1:0] pre_target;
  logic              ex_br_valid;
  logic [ADDR_W-1:0] ex_br_pc;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              ex_pre_fail;

  modport master (
    output rdy, if_pc, ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target, ex_pre_fail,
    input  pre_jmp, pre_target
  );

  modport slave (
    input  rdy, if_pc, ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target, ex_pre_fail,
    output pre_jmp, pre_target
  );

endinterface

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped predictor storage: valid/tag/target/counter per entry,
// one synchronous write port and two combinational read ports (fetch lookup, EX update).
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_INDEX_BITS,
  parameter int TAG_W = BP_TAG_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  ra_idx_i,
  output logic              ra_valid_o,
  output logic [TAG_W-1:0]  ra_tag_o,
  output logic [ADDR_W-1:0] ra_target_o,
  output ctr_e              ra_ctr_o,
  input  logic [IDX_W-1:0]  rb_idx_i,
  output logic              rb_valid_o,
  output logic [TAG_W-1:0]  rb_tag_o,
  output logic [ADDR_W-1:0] rb_target_o,
  output ctr_e              rb_ctr_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  w_idx_i,
  input  logic [TAG_W-1:0]  w_tag_i,
  input  logic [ADDR_W-1:0] w_target_i,
  input  ctr_e              w_ctr_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  ctr_e              ctr_q    [DEPTH];

  // Every write either allocates or refreshes a live entry, so valid is always set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (we_i) begin
      valid_q[w_idx_i]  <= 1'b1;
      tag_q[w_idx_i]    <= w_tag_i;
      target_q[w_idx_i] <= w_target_i;
      ctr_q[w_idx_i]    <= w_ctr_i;
    end
  end

  assign ra_valid_o  = valid_q[ra_idx_i];
  assign ra_tag_o    = tag_q[ra_idx_i];
  assign ra_target_o = target_q[ra_idx_i];
  assign ra_ctr_o    = ctr_q[ra_idx_i];

  assign rb_valid_o  = valid_q[rb_idx_i];
  assign rb_tag_o    = tag_q[rb_idx_i];
  assign rb_target_o = target_q[rb_idx_i];
  assign rb_ctr_o    = ctr_q[rb_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped table with 2-bit saturating counters, trained from EX.
// Optional performance counters are built when BP_PERF_CNT_EN is defined.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int TAG_BITS   = BP_TAG_BITS
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]        perf_br_cnt,
  output logic [31:0]        perf_miss_cnt
`endif
);

  logic [INDEX_BITS-1:0] l_idx, u_idx;
  logic [TAG_BITS-1:0]   l_tag, u_tag;
  logic                  l_valid, u_valid;
  logic [TAG_BITS-1:0]   l_tag_q, u_tag_q;
  logic [ADDR_W-1:0]     l_target, u_target;
  ctr_e                  l_ctr, u_ctr;
  logic                  l_hit, u_hit;
  logic                  upd;
  ctr_e                  w_ctr;
  logic [ADDR_W-1:0]     w_target;

  assign l_idx = bp.if_pc[INDEX_BITS+1:2];
  assign l_tag = bp.if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign u_idx = bp.ex_br_pc[INDEX_BITS+1:2];
  assign u_tag = bp.ex_br_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  bp_table #(
    .IDX_W (INDEX_BITS),
    .TAG_W (TAG_BITS)
  ) u_bp_table (
    .clk         (clk),
    .rst         (rst),
    .ra_idx_i    (l_idx),
    .ra_valid_o  (l_valid),
    .ra_tag_o    (l_tag_q),
    .ra_target_o (l_target),
    .ra_ctr_o    (l_ctr),
    .rb_idx_i    (u_idx),
    .rb_valid_o  (u_valid),
    .rb_tag_o    (u_tag_q),
    .rb_target_o (u_target),
    .rb_ctr_o    (u_ctr),
    .we_i        (upd),
    .w_idx_i     (u_idx),
    .w_tag_i     (u_tag),
    .w_target_i  (w_target),
    .w_ctr_i     (w_ctr)
  );

  assign l_hit          = l_valid && (l_tag_q == l_tag);
  assign bp.pre_jmp     = l_hit && l_ctr[1];
  assign bp.pre_target  = bp.pre_jmp ? l_target : bp.if_pc + 32'd4;

  assign u_hit = u_valid && (u_tag_q == u_tag);
  assign upd   = bp.rdy && bp.ex_br_valid;

  // Hit: saturating train, target refreshed only on taken. Miss: allocate fresh entry.
  always_comb begin
    w_ctr    = CTR_RESET;
    w_target = '0;
    if (u_hit) begin
      w_ctr    = u_ctr;
      w_target = u_target;
      if (bp.ex_br_taken) begin
        w_target = bp.ex_br_target;
        if (u_ctr != CTR_ST) w_ctr = ctr_e'(u_ctr + 2'd1);
      end else if (u_ctr != CTR_SNT) begin
        w_ctr = ctr_e'(u_ctr - 2'd1);
      end
    end else if (bp.ex_br_taken) begin
      w_ctr    = CTR_WT;
      w_target = bp.ex_br_target;
    end else begin
      w_ctr    = CTR_WNT;
      w_target = bp.ex_br_pc + 32'd4;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_cnt_q, perf_br_cnt_d;
  logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;

  always_comb begin
    perf_br_cnt_d   = perf_br_cnt_q;
    perf_miss_cnt_d = perf_miss_cnt_q;
    if (upd) begin
      perf_br_cnt_d = perf_br_cnt_q + 32'd1;
      if (bp.ex_pre_fail) perf_miss_cnt_d = perf_miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_cnt_q   <= '0;
      perf_miss_cnt_q <= '0;
    end else begin
      perf_br_cnt_q   <= perf_br_cnt_d;
      perf_miss_cnt_q <= perf_miss_cnt_d;
    end
  end

  assign perf_br_cnt   = perf_br_cnt_q;
  assign perf_miss_cnt = perf_miss_cnt_q;
`else
  logic unused_pre_fail;
  assign unused_pre_fail = bp.ex_pre_fail;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written reset/perf
// sequences, and randomized traffic against a behavioural table model.
module tb_branch_predictor;

  localparam int IDX   = 7;
  localparam int TAGB  = 10;
  localparam int DEPTH = 1 << IDX;

  logic clk;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  branch_predictor_if bp ();

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_cnt, perf_miss_cnt;
`endif

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_br_cnt   (perf_br_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a plain array of entries indexed by arithmetic on the PC.
  bit          m_valid  [DEPTH];
  int          m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_ctr    [DEPTH];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int m_tagof(input logic [31:0] pc);
    return int'((pc >> (IDX + 2)) % (1 << TAGB));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic jmp, output logic [31:0] tgt);
    int i;
    i   = m_idx(pc);
    jmp = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    tgt = jmp ? m_target[i] : pc + 32'd4;
  endtask

  task automatic m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (taken) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else begin
      m_valid[i]  = 1;
      m_tag[i]    = m_tagof(pc);
      m_target[i] = taken ? tgt : pc + 32'd4;
      m_ctr[i]    = taken ? 2 : 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic v, input logic [31:0] bpc, input logic tk,
                       input logic [31:0] btgt, input logic pf, input logic [31:0] lpc);
    bp.rdy          = rdy;
    bp.ex_br_valid  = v;
    bp.ex_br_pc     = bpc;
    bp.ex_br_taken  = tk;
    bp.ex_br_target = btgt;
    bp.ex_pre_fail  = pf;
    bp.if_pc        = lpc;
  endtask

  // Advance one clock; model learns whatever the DUT should have accepted.
  task automatic step();
    logic acc;
    acc = bp.rdy && bp.ex_br_valid;
    @(posedge clk);
    #1;
    if (acc) m_update(bp.ex_br_pc, bp.ex_br_taken, bp.ex_br_target);
  endtask

  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] bpc;
    logic        tk;
    logic [31:0] btgt;
    logic [31:0] lpc;
    logic        exp_jmp;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic v, input logic [31:0] bpc,
                              input logic tk, input logic [31:0] btgt, input logic [31:0] lpc,
                              input logic ej, input logic [31:0] et);
    vec_t r;
    r.rdy = rdy; r.v = v; r.bpc = bpc; r.tk = tk; r.btgt = btgt;
    r.lpc = lpc; r.exp_jmp = ej; r.exp_tgt = et;
    return r;
  endfunction

  initial begin
    logic        ej;
    logic [31:0] et, p, lp;

    // Expected values are what the lookup shows during the cycle, before that cycle's update lands.
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h80,  32'h100, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h100, 0, 32'h0,   32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 1, 32'h100, 0, 32'h0,   32'h100, 1, 32'h80));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104));
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h90,  32'h100, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h90));
    vecs.push_back(mk(1, 1, 32'h300, 0, 32'h0,   32'h300, 0, 32'h304));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h300, 0, 32'h304));
    vecs.push_back(mk(1, 1, 32'h300, 1, 32'h40,  32'h300, 0, 32'h304));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h300, 1, 32'h40));
    vecs.push_back(mk(0, 1, 32'h200, 1, 32'h500, 32'h200, 0, 32'h204));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h200, 0, 32'h204));
    vecs.push_back(mk(0, 1, 32'h300, 0, 32'h0,   32'h300, 1, 32'h40));
    vecs.push_back(mk(0, 1, 32'h300, 0, 32'h0,   32'h300, 1, 32'h40));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h300, 1, 32'h40));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h303, 1, 32'h40));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h102, 0, 32'h106));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h80000300, 1, 32'h40));

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h1000);
    m_reset();
    #2;
    chk("reset_pre_jmp", {31'b0, bp.pre_jmp}, 32'h0);
    chk("reset_pre_target", bp.pre_target, 32'h1004);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rdy, vecs[k].v, vecs[k].bpc, vecs[k].tk, vecs[k].btgt, 1'b0, vecs[k].lpc);
      #2;
      chk($sformatf("vec%0d_pre_jmp", k), {31'b0, bp.pre_jmp}, {31'b0, vecs[k].exp_jmp});
      chk($sformatf("vec%0d_pre_target", k), bp.pre_target, vecs[k].exp_tgt);
      step();
    end

    // Async reset mid-cycle with an update pending
    drive(1, 1, 32'h1000, 1, 32'h2000, 0, 32'h1000);
    step();
    drive(1, 0, 0, 0, 0, 0, 32'h1000);
    #1;
    chk("pre_rst_trained_jmp", {31'b0, bp.pre_jmp}, 32'h1);
    chk("pre_rst_trained_target", bp.pre_target, 32'h2000);
    drive(1, 1, 32'h1000, 1, 32'h3000, 0, 32'h1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pre_jmp", {31'b0, bp.pre_jmp}, 32'h0);
    chk("async_rst_pre_target", bp.pre_target, 32'h1004);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 32'h1000);
    #1;
    chk("post_rst_pre_jmp", {31'b0, bp.pre_jmp}, 32'h0);
    chk("post_rst_pre_target", bp.pre_target, 32'h1004);
    step();

    // Randomized traffic against the model, confined to a few indices/tags so entries collide
    for (int n = 0; n < 400; n++) begin
      p = $urandom;
      p[IDX+1:2] = 7'(60 + $urandom_range(0, 5));
      p[IDX+TAGB+1:IDX+2] = 10'($urandom_range(0, 2));
      lp = $urandom;
      if ($urandom_range(0, 2) == 0) lp = p;
      else begin
        lp[IDX+1:2] = 7'(60 + $urandom_range(0, 5));
        lp[IDX+TAGB+1:IDX+2] = 10'($urandom_range(0, 2));
      end
      drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1), p, $urandom_range(0, 2) != 0,
            $urandom, 1'b0, lp);
      #2;
      m_predict(lp, ej, et);
      chk($sformatf("rand%0d_pre_jmp", n), {31'b0, bp.pre_jmp}, {31'b0, ej});
      chk($sformatf("rand%0d_pre_target", n), bp.pre_target, et);
      step();
    end

`ifdef BP_PERF_CNT_EN
    rst = 1'b1;
    #3 rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) begin
      drive(1, 1, 32'h400 + 32'(n * 4), n[0], 32'h0, (n == 1 || n == 3), 32'h0);
      step();
    end
    drive(0, 1, 32'h400, 1, 32'h0, 1, 32'h0);
    step();
    drive(1, 0, 32'h400, 1, 32'h0, 1, 32'h0);
    step();
    chk("perf_br_cnt", perf_br_cnt, 32'd5);
    chk("perf_miss_cnt", perf_miss_cnt, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("perf_br_cnt_rst", perf_br_cnt, 32'd0);
    chk("perf_miss_cnt_rst", perf_miss_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
